// File: rtl/rossler_seq_ctrl_if.sv
// Control/handshake bundle between the Rossler step sequencer and its host/consumer.
// master = host and consumer side, slave = sequencer side.
interface rossler_seq_ctrl_if #(
  parameter int IterWidth = 32
);
  logic                 i_start;
  logic                 i_abort;
  logic [IterWidth-1:0] i_n_iter;
  logic                 i_out_ready;
  logic                 o_sel_init;
  logic                 o_en;
  logic                 o_out_valid;
  logic                 o_busy;
  logic                 o_done;
  logic [IterWidth-1:0] o_iter;

  modport master (
    output i_start, i_abort, i_n_iter, i_out_ready,
    input  o_sel_init, o_en, o_out_valid, o_busy, o_done, o_iter
  );

  modport slave (
    input  i_start, i_abort, i_n_iter, i_out_ready,
    output o_sel_init, o_en, o_out_valid, o_busy, o_done, o_iter
  );
endinterface

// File: rtl/rossler_seq_ctrl.sv
// Step sequencer for the fixed-point Euler integrator of the Rossler attractor datapath.
// Optional output decimation is enabled by defining ROSSLER_SEQ_DECIM_EN.
module rossler_seq_ctrl #(
  parameter int IterWidth = 32,
  parameter int Latency   = 3,
  parameter int Decim     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  rossler_seq_ctrl_if.slave ctrl_if
);

  localparam int              LatW    = (Latency > 1) ? $clog2(Latency) : 1;
  localparam logic [LatW-1:0] LatLoad = (Latency > 0) ? LatW'(Latency - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_CALC   = 3'd2,
    S_UPDATE = 3'd3,
    S_OUT    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  state_t               w_step_state;
  logic [LatW-1:0]      r_lat;
  logic [LatW-1:0]      w_lat_next;
  logic [IterWidth-1:0] r_iter;
  logic [IterWidth-1:0] w_iter_next;
  logic [IterWidth-1:0] r_n_iter;
  logic [IterWidth-1:0] w_n_iter_next;

  if (Decim < 1) begin : g_bad_decim
    $error("rossler_seq_ctrl: Decim must be >= 1");
  end

`ifdef ROSSLER_SEQ_DECIM_EN
  localparam int              DecW    = (Decim > 1) ? $clog2(Decim) : 1;
  localparam logic [DecW-1:0] DecLast = DecW'(Decim - 1);

  logic [DecW-1:0] r_dec;
  logic [DecW-1:0] w_dec_next;
  logic            w_last_step;

  assign w_last_step = ((r_iter + IterWidth'(1)) == r_n_iter);
`endif

  // With zero datapath latency there is no wait state between commits.
  assign w_step_state = (Latency > 0) ? S_CALC : S_UPDATE;

  always_comb begin
    w_state_next  = r_state;
    w_lat_next    = r_lat;
    w_iter_next   = r_iter;
    w_n_iter_next = r_n_iter;
`ifdef ROSSLER_SEQ_DECIM_EN
    w_dec_next    = r_dec;
`endif
    case (r_state)
      S_IDLE: begin
        if (ctrl_if.i_start) begin
          w_n_iter_next = ctrl_if.i_n_iter;
          w_iter_next   = '0;
          w_state_next  = (ctrl_if.i_n_iter == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        w_state_next = w_step_state;
        w_lat_next   = LatLoad;
`ifdef ROSSLER_SEQ_DECIM_EN
        w_dec_next   = '0;
`endif
      end
      S_CALC: begin
        if (r_lat == '0) begin
          w_state_next = S_UPDATE;
        end else begin
          w_lat_next = r_lat - LatW'(1);
        end
      end
      S_UPDATE: begin
        w_iter_next = r_iter + IterWidth'(1);
`ifdef ROSSLER_SEQ_DECIM_EN
        // The final step is always presented, whatever the decimation phase.
        if ((r_dec == DecLast) || w_last_step) begin
          w_state_next = S_OUT;
          w_dec_next   = '0;
        end else begin
          w_state_next = w_step_state;
          w_lat_next   = LatLoad;
          w_dec_next   = r_dec + DecW'(1);
        end
`else
        w_state_next = S_OUT;
`endif
      end
      S_OUT: begin
        if (ctrl_if.i_out_ready) begin
          if (r_iter == r_n_iter) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = w_step_state;
            w_lat_next   = LatLoad;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Abort wins over start and over the output handshake; counters are left as computed.
    if ((r_state != S_IDLE) && ctrl_if.i_abort) begin
      w_state_next = S_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= S_IDLE;
      r_lat    <= '0;
      r_iter   <= '0;
      r_n_iter <= '0;
    end else begin
      r_state  <= w_state_next;
      r_lat    <= w_lat_next;
      r_iter   <= w_iter_next;
      r_n_iter <= w_n_iter_next;
    end
  end

`ifdef ROSSLER_SEQ_DECIM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_dec <= '0;
    end else begin
      r_dec <= w_dec_next;
    end
  end
`endif

  assign ctrl_if.o_sel_init  = (r_state == S_LOAD);
  assign ctrl_if.o_en        = (r_state == S_LOAD) || (r_state == S_UPDATE);
  assign ctrl_if.o_out_valid = (r_state == S_OUT);
  assign ctrl_if.o_busy      = (r_state != S_IDLE);
  assign ctrl_if.o_done      = (r_state == S_DONE);
  assign ctrl_if.o_iter      = r_iter;

endmodule

// File: tb/tb_rossler_seq_ctrl.sv
// Self-checking bench for rossler_seq_ctrl: directed scenarios plus randomized runs
// compared cycle by cycle against a schedule built from the step-timing rules.
module tb_rossler_seq_ctrl;
  localparam int IW   = 8;
  localparam int LAT  = 3;
  localparam int DEC  = 3;
  localparam int VW   = 5 + IW;
  localparam int MAXT = 256;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int errors = 0;
  int checks = 0;

  // Expected per-cycle view: flags = {sel_init, en, out_valid, busy, done}.
  logic [4:0] exp_flags [MAXT];
  int         exp_it    [MAXT];
  bit         exp_rdy   [MAXT];

  rossler_seq_ctrl_if #(.IterWidth(IW)) bus ();

  rossler_seq_ctrl #(
    .IterWidth(IW),
    .Latency  (LAT),
    .Decim    (DEC)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ctrl_if(bus)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [VW-1:0] obs_vec();
    return {bus.o_sel_init, bus.o_en, bus.o_out_valid, bus.o_busy, bus.o_done, bus.o_iter};
  endfunction

  task automatic check(input string tag, input int t, input logic [VW-1:0] obs,
                       input logic [VW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, t, obs, expv);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, leave the caller at the falling edge.
  task automatic tick(input bit st, input bit ab, input bit rdy, input int n);
    @(posedge clk_i);
    #1;
    bus.i_start     = st;
    bus.i_abort     = ab;
    bus.i_out_ready = rdy;
    bus.i_n_iter    = IW'(n);
    @(negedge clk_i);
  endtask

  // Builds the expected schedule of a whole run, then drives and checks it.
  task automatic run(input string tag, input int n, input int s_first, input int s_max,
                     input bit noise);
    int  cur;
    int  s;
    int  last;
    bit  emit;
    bit  first;
    for (int i = 0; i < MAXT; i++) begin
      exp_flags[i] = '0;
      exp_it[i]    = 0;
      exp_rdy[i]   = 1'b1;
    end
    first = 1'b1;
    cur   = 1;
    if (n > 0) begin
      exp_flags[1] = 5'b11010;
      exp_it[1]    = 0;
      cur          = 2;
      for (int k = 1; k <= n; k++) begin
        for (int j = 0; j < LAT; j++) begin
          exp_flags[cur] = 5'b00010;
          exp_it[cur]    = k - 1;
          cur++;
        end
        exp_flags[cur] = 5'b01010;
        exp_it[cur]    = k - 1;
        cur++;
`ifdef ROSSLER_SEQ_DECIM_EN
        emit = ((k % DEC) == 0) || (k == n);
`else
        emit = 1'b1;
`endif
        if (emit) begin
          s     = first ? s_first : int'($urandom_range(s_max, 0));
          first = 1'b0;
          for (int j = 0; j <= s; j++) begin
            exp_flags[cur] = 5'b00110;
            exp_it[cur]    = k;
            exp_rdy[cur]   = (j == s);
            cur++;
          end
        end
      end
    end
    exp_flags[cur] = 5'b00011;
    exp_it[cur]    = n;
    cur++;
    exp_flags[cur] = 5'b00000;
    exp_it[cur]    = n;
    last = cur;

    for (int t = 0; t <= last; t++) begin
      @(posedge clk_i);
      #1;
      bus.i_abort = 1'b0;
      if (t == 0) begin
        bus.i_start     = 1'b1;
        bus.i_n_iter    = IW'(n);
        bus.i_out_ready = 1'b1;
      end else begin
        bus.i_start     = noise && (t < last) && ($urandom_range(3, 0) == 0);
        bus.i_n_iter    = noise ? IW'($urandom) : IW'(n);
        bus.i_out_ready = exp_flags[t][2] ? exp_rdy[t] : (noise ? 1'($urandom) : 1'b1);
      end
      @(negedge clk_i);
      if (t > 0) check(tag, t, obs_vec(), {exp_flags[t], IW'(exp_it[t])});
    end
    bus.i_start = 1'b0;
  endtask

  initial begin
    bus.i_start     = 1'b0;
    bus.i_abort     = 1'b0;
    bus.i_out_ready = 1'b1;
    bus.i_n_iter    = '0;

    // Reset state
    @(negedge clk_i);
    check("reset", 0, obs_vec(), '0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_reset", 0, obs_vec(), '0);

    run("normal", 4, 0, 0, 1'b0);
    run("backpressure", 2, 5, 0, 1'b0);
    run("zero_iter", 0, 0, 0, 1'b0);

    // Reset in CALC of step 2: outputs drop in the same cycle, no done afterwards
    tick(1'b1, 1'b0, 1'b1, 4);
    for (int t = 1; t <= 8; t++) tick(1'b0, 1'b0, 1'b1, 4);
    check("rst_pre", 8, obs_vec(), {5'b00010, IW'(1)});
    rst_i = 1'b1;
    #1;
    check("rst_async", 8, obs_vec(), '0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick(1'b0, 1'b0, 1'b1, 4);
      check("rst_idle", t, obs_vec(), '0);
    end
    run("after_reset", 3, 0, 0, 1'b0);

    // Abort in CALC of step 3
    tick(1'b1, 1'b0, 1'b1, 10);
    for (int t = 1; t <= 12; t++) tick(1'b0, 1'b0, 1'b1, 10);
    tick(1'b0, 1'b1, 1'b1, 10);
    check("abort_calc_pre", 13, obs_vec(), {5'b00010, IW'(2)});
    for (int t = 14; t < 22; t++) begin
      tick(1'b0, 1'b0, 1'b1, 10);
      check("abort_calc_idle", t, obs_vec(), {5'b00000, IW'(2)});
    end

    // Abort coincident with the first OUT handshake
    tick(1'b1, 1'b0, 1'b1, 3);
    for (int t = 1; t <= 5; t++) tick(1'b0, 1'b0, 1'b1, 3);
    tick(1'b0, 1'b1, 1'b1, 3);
    check("abort_out_pre", 6, obs_vec(), {5'b00110, IW'(1)});
    for (int t = 7; t < 11; t++) begin
      tick(1'b0, 1'b0, 1'b1, 3);
      check("abort_out_idle", t, obs_vec(), {5'b00000, IW'(1)});
    end

`ifdef ROSSLER_SEQ_DECIM_EN
    run("decim", 7, 0, 0, 1'b0);
`endif

    for (int r = 0; r < 12; r++) begin
      run("random", int'($urandom_range(9, 0)), int'($urandom_range(3, 0)), 3, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rossler_seq_ctrl.md
Name: rossler_seq_ctrl

Overview:
- Sequencer for the fixed-point Euler integrator of the chaotic-attractor datapath.
- Drives the enable and initial-condition select shared by all state registers (x, y, z enable flip-flops).
- Waits out the combinational/pipelined arithmetic latency, then commits one integration step.
- Presents each new state to a downstream consumer (DAC/UART/logger) over a valid/ready handshake, and counts iterations up to a programmed total.

Parameters:
IterWidth, 32, width of iteration count and n_iter_i
Latency, 3, cycles the f(x,y,z) datapath needs after a register update before its next value is valid (0 allowed)
Decim, 4, output decimation factor; only used when ROSSLER_SEQ_DECIM_EN is defined (must be >= 1)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; asynchronous, active-high
start_i  in  1  start a run; sampled only in IDLE
abort_i  in  1  terminate run; no done pulse
n_iter_i  in  IterWidth  number of integration steps; latched on start
out_ready_i  in  1  consumer ready
sel_init_o  out  1  state-register input mux: 1 = initial conditions, 0 = integrator result
en_o  out  1  state-register enable (one-cycle pulses)
out_valid_o  out  1  state registers hold a new sample
busy_o  out  1  run in progress (state != IDLE)
done_o  out  1  one-cycle pulse at normal completion
iter_o  out  IterWidth  completed steps in current/last run

Behaviour:
- Reset: state IDLE; all outputs 0; internal latency counter, latched n_iter and iter_o cleared. Reset mid-run returns to IDLE immediately with no en_o or done_o pulse.
- Outputs are Moore-decoded from registered state and counters; no combinational path from any input to any output.
- IDLE: busy_o=0.
  - start_i=1 latches n_iter_i and clears iter_o.
  - If n_iter_i==0, go to DONE; otherwise go to LOAD.
- LOAD (1 cycle): sel_init_o=1, en_o=1; registers capture initial conditions.
  - Go to CALC if Latency>0, else UPDATE.
- CALC (exactly Latency cycles, down-counter): all strobes 0, then UPDATE.
- UPDATE (1 cycle): en_o=1, sel_init_o=0; iter_o increments at end of cycle. Then OUT.
- OUT: out_valid_o=1, held stable until out_ready_i=1. en_o=0 while stalled, so register contents are frozen.
  - Handshake with iter_o==n_iter: go to DONE.
  - Handshake otherwise: go to CALC (or UPDATE if Latency==0).
- DONE (1 cycle): done_o=1, busy_o=1; then IDLE. iter_o holds final count until next start or reset.
- Step period with ready high: Latency+2 cycles. First en_o after LOAD follows Latency+1 cycles later.
- abort_i=1 in any non-IDLE state: next state IDLE; no done_o. Outputs in the abort cycle follow the current state, so an UPDATE-cycle en_o still fires; iter_o keeps its value.
- abort_i has priority over start_i and over the OUT handshake in the same cycle.
- start_i while busy is ignored. n_iter_i changes mid-run are ignored.
- iter_o never wraps: the maximum n_iter is 2^IterWidth-1 and the terminal compare is equality.

Optional Feature:
ROSSLER_SEQ_DECIM_EN
- Defined:
  - A decimation counter (cleared in LOAD) counts UPDATEs.
  - OUT is entered only when the counter reaches Decim (counter then resets) or when iter_o==n_iter after the update. The final sample is always emitted.
  - Otherwise UPDATE goes directly to CALC (or UPDATE when Latency==0), with no out_valid_o.
  - Decim=1 behaves identically to undefined.
- Undefined: every UPDATE is followed by OUT; Decim parameter unused, no counter logic.

Test Plan:
- Reset mid-run: assert rst_i during CALC of step 2 -> same-cycle outputs all 0, busy_o=0, iter_o=0, no done_o. A subsequent start_i runs normally.
- Normal run: Latency=3, n_iter_i=4, out_ready_i=1, start_i at cycle 0 -> LOAD at cycle 1 (sel_init_o=en_o=1); en_o at cycles 5, 10, 15, 20; out_valid_o at 6, 11, 16, 21; iter_o 1..4; done_o at 22; busy_o low at 23.
- Backpressure: n_iter_i=2, out_ready_i low for 5 cycles in first OUT -> out_valid_o held 6 cycles, no en_o during stall, iter_o stays 1; second en_o 4 cycles after handshake.
- Zero iterations and busy-start: n_iter_i=0 -> done_o one cycle after start, no en_o/out_valid_o, iter_o=0. start_i pulsed during a run -> no effect on count or timing.
- Abort: abort_i during CALC of step 3 (n_iter_i=10) -> IDLE next cycle, iter_o=2, no done_o, no further en_o. Abort coincident with OUT handshake -> IDLE, no CALC.
- Decimation (macro defined, Decim=3, n_iter_i=7, ready=1) -> out_valid_o only after iterations 3, 6, 7; seven en_o pulses plus LOAD; done_o after the iteration-7 handshake.
